// File: rtl/kfmmc_exerciser_pkg.sv
// kfmmc_exerciser_pkg: shared types and constants for the MMC block exerciser
package kfmmc_exerciser_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_READY, S_ADDR1, S_ADDR2, S_ADDR3, S_ADDR4, S_CMD, S_WAIT_INT,
    S_SEND_DATA, S_RECV_DATA, S_ACK_RESULT, S_WAIT_BUSY, S_NEXT, S_DONE
  } state_t;
  typedef enum logic [1:0] {MODE_WRITE, MODE_READ, MODE_WRITE_VERIFY, MODE_RESERVED} mode_t;
  typedef enum logic [2:0] {ABORT_NONE, ABORT_WR_IF, ABORT_RD_IF, ABORT_CRC, ABORT_TIMEOUT} abort_t;
  localparam logic [7:0] CMD_READ = 8'h80;
  localparam logic [7:0] CMD_WRITE = 8'h81;
  localparam int BLOCK_BYTES = 512;
endpackage

// File: rtl/kfmmc_pattern_gen.sv
// kfmmc_pattern_gen: seeded byte pattern, in-block byte index and saturating compare-error counter
module kfmmc_pattern_gen
  import kfmmc_exerciser_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [7:0]           seed_i,
  input  logic [7:0]           blk_i,
  input  logic                 idx_clr_i,
  input  logic                 idx_inc_i,
  input  logic                 cmp_i,
  input  logic [7:0]           data_i,
  output logic [7:0]           pattern_o,
  output logic [ERR_CNT_W-1:0] mismatch_o
);
  localparam int IDX_W = $clog2(BLOCK_BYTES);
  logic [7:0] seed_q;
  logic [IDX_W-1:0] idx_q;
  logic [ERR_CNT_W-1:0] err_q;
  assign pattern_o = seed_q + blk_i + idx_q[7:0];
  assign mismatch_o = err_q;
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      seed_q <= '0;
      idx_q <= '0;
      err_q <= '0;
    end else begin
      seed_q <= load_i ? seed_i : seed_q;
      idx_q <= idx_clr_i ? '0 : idx_q + IDX_W'(idx_inc_i);
      err_q <= load_i ? '0 : (cmp_i && data_i != pattern_o && !(&err_q)) ? err_q + 1'b1 : err_q;
    end
  end
endmodule

// File: rtl/kfmmc_block_exerciser.sv
// kfmmc_block_exerciser: block write/read/verify sequencer on the KFMMC_Drive host interface.
// State changes on the falling clock edge so the drive sees stable strobes on its rising edge.
module kfmmc_block_exerciser
  import kfmmc_exerciser_pkg::*;
#(
  parameter int          BLOCK_CNT_W = 16,
  parameter int          ERR_CNT_W   = 16,
  parameter logic [31:0] TIMEOUT     = 32'h00FFFFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [31:0]            start_block,
  input  logic [BLOCK_CNT_W-1:0] block_count,
  input  logic [7:0]             seed,
  output logic [7:0]             internal_data_bus,
  output logic                   write_block_address_1,
  output logic                   write_block_address_2,
  output logic                   write_block_address_3,
  output logic                   write_block_address_4,
  output logic                   write_access_command,
  output logic                   write_data,
  output logic                   read_data,
  input  logic [7:0]             read_data_byte,
  input  logic                   drive_busy,
  input  logic                   block_read_interrupt,
  input  logic                   read_completion_interrupt,
  input  logic                   request_write_data_interrupt,
  input  logic                   write_completion_interrupt,
  input  logic                   read_interface_error,
  input  logic                   read_crc_error,
  input  logic                   write_interface_error,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2:0]             abort_code,
  output logic [BLOCK_CNT_W-1:0] blocks_done,
  output logic [ERR_CNT_W-1:0]   mismatch_count
);
  state_t state_q, state_d;
  mode_t mode_q;
  abort_t abort_q, abort_d;
  logic read_ph_q, read_ph_d, tmo, load;
  logic [31:0] blk_q, blk_d, tmr_q;
  logic [BLOCK_CNT_W-1:0] cnt_q, done_q, done_d;
  logic [7:0] pattern;
  assign tmo = tmr_q == TIMEOUT - 32'd1;
  assign load = start && (state_q == S_IDLE || state_q == S_DONE);
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    done_d = done_q;
    abort_d = abort_q;
    read_ph_d = read_ph_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        blk_d = start_block;
        read_ph_d = mode == 2'(MODE_READ);
        done_d = '0;
        abort_d = ABORT_NONE;
        state_d = block_count == '0 ? S_DONE : S_WAIT_READY;
      end
      S_WAIT_READY: state_d = !drive_busy ? S_ADDR1 : tmo ? S_DONE : S_WAIT_READY;
      S_ADDR1: state_d = S_ADDR2;
      S_ADDR2: state_d = S_ADDR3;
      S_ADDR3: state_d = S_ADDR4;
      S_ADDR4: state_d = S_CMD;
      S_CMD: state_d = S_WAIT_INT;
      S_WAIT_INT: begin
        // errors outrank any interrupt raised in the same cycle
        abort_d = write_interface_error ? ABORT_WR_IF : read_interface_error ? ABORT_RD_IF :
                  read_crc_error ? ABORT_CRC : abort_q;
        state_d = (write_interface_error || read_interface_error || read_crc_error) ? S_DONE :
                  (write_completion_interrupt || read_completion_interrupt) ? S_ACK_RESULT :
                  request_write_data_interrupt ? S_SEND_DATA :
                  block_read_interrupt ? S_RECV_DATA : tmo ? S_DONE : S_WAIT_INT;
      end
      S_SEND_DATA: state_d = !request_write_data_interrupt ? S_WAIT_INT : tmo ? S_DONE : S_SEND_DATA;
      S_RECV_DATA: state_d = !block_read_interrupt ? S_WAIT_INT : tmo ? S_DONE : S_RECV_DATA;
      S_ACK_RESULT: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: state_d = !drive_busy ? S_NEXT : tmo ? S_DONE : S_WAIT_BUSY;
      S_NEXT: if (mode_q == MODE_WRITE_VERIFY && !read_ph_q) begin
        read_ph_d = 1'b1;
        state_d = S_ADDR1;
      end else begin
        done_d = done_q + 1'b1;
        blk_d = blk_q + 32'd1;
        read_ph_d = mode_q == MODE_READ;
        state_d = done_d == cnt_q ? S_DONE : S_ADDR1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && abort_d == ABORT_NONE && tmo &&
        (state_q == S_WAIT_READY || state_q == S_WAIT_INT || state_q == S_SEND_DATA ||
         state_q == S_RECV_DATA || state_q == S_WAIT_BUSY))
      abort_d = ABORT_TIMEOUT;
  end
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= MODE_WRITE;
      abort_q <= ABORT_NONE;
      read_ph_q <= 1'b0;
      blk_q <= '0;
      tmr_q <= '0;
      cnt_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= load ? mode_t'(mode) : mode_q;
      cnt_q <= load ? block_count : cnt_q;
      abort_q <= abort_d;
      read_ph_q <= read_ph_d;
      blk_q <= blk_d;
      done_q <= done_d;
      tmr_q <= state_d != state_q ? '0 : tmr_q + 32'd1;
    end
  end
  kfmmc_pattern_gen #(.ERR_CNT_W(ERR_CNT_W)) u_pat (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load),
    .seed_i     (seed),
    .blk_i      (blk_q[7:0]),
    .idx_clr_i  (state_q == S_CMD),
    .idx_inc_i  ((state_q == S_SEND_DATA || state_q == S_RECV_DATA) && state_d != state_q),
    .cmp_i      (state_q == S_RECV_DATA && tmr_q == '0),
    .data_i     (read_data_byte),
    .pattern_o  (pattern),
    .mismatch_o (mismatch_count)
  );
  // strobes decode straight from the state register so an async reset drops them at once
  assign write_block_address_1 = state_q == S_ADDR1;
  assign write_block_address_2 = state_q == S_ADDR2;
  assign write_block_address_3 = state_q == S_ADDR3;
  assign write_block_address_4 = state_q == S_ADDR4;
  assign write_access_command = state_q == S_CMD;
  assign write_data = state_q == S_SEND_DATA;
  assign read_data = state_q == S_RECV_DATA || state_q == S_ACK_RESULT;
  assign internal_data_bus = state_q == S_ADDR1 ? blk_q[7:0] : state_q == S_ADDR2 ? blk_q[15:8] :
                             state_q == S_ADDR3 ? blk_q[23:16] : state_q == S_ADDR4 ? blk_q[31:24] :
                             state_q == S_CMD ? (read_ph_q ? CMD_READ : CMD_WRITE) :
                             state_q == S_SEND_DATA ? pattern : 8'h00;
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign done = state_q == S_DONE;
  assign pass = done && abort_q == ABORT_NONE && mismatch_count == '0;
  assign abort_code = abort_q;
  assign blocks_done = done_q;
endmodule

// File: tb/tb_kfmmc_block_exerciser.sv
// tb_kfmmc_block_exerciser: directed checks of the exerciser against a behavioural KFMMC_Drive model
module tb_kfmmc_block_exerciser;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [31:0] start_block = '0;
  logic [15:0] block_count = '0, blocks_done, mismatch_count;
  logic [7:0] seed = '0, internal_data_bus, read_data_byte = '0;
  logic wba1, wba2, wba3, wba4, write_access_command, write_data, read_data;
  logic drive_busy = 0, block_read_interrupt = 0, read_completion_interrupt = 0;
  logic request_write_data_interrupt = 0, write_completion_interrupt = 0;
  logic read_interface_error = 0, read_crc_error = 0, write_interface_error = 0;
  logic busy, done, pass;
  logic [2:0] abort_code;
  int tests = 0, fails = 0, n;

  kfmmc_block_exerciser #(.BLOCK_CNT_W(16), .ERR_CNT_W(16), .TIMEOUT(32'd16)) dut (
    .clock(clk), .reset(reset), .start(start), .mode(mode), .start_block(start_block),
    .block_count(block_count), .seed(seed), .internal_data_bus(internal_data_bus),
    .write_block_address_1(wba1), .write_block_address_2(wba2), .write_block_address_3(wba3),
    .write_block_address_4(wba4), .write_access_command(write_access_command),
    .write_data(write_data), .read_data(read_data), .read_data_byte(read_data_byte),
    .drive_busy(drive_busy), .block_read_interrupt(block_read_interrupt),
    .read_completion_interrupt(read_completion_interrupt),
    .request_write_data_interrupt(request_write_data_interrupt),
    .write_completion_interrupt(write_completion_interrupt),
    .read_interface_error(read_interface_error), .read_crc_error(read_crc_error),
    .write_interface_error(write_interface_error), .busy(busy), .done(done), .pass(pass),
    .abort_code(abort_code), .blocks_done(blocks_done), .mismatch_count(mismatch_count));

  always #5 clk = ~clk;

  // drive model: acts on the rising edge, the DUT moves on the falling edge
  logic [31:0] m_addr;
  logic [7:0] m_cmd, m_seed;
  logic m_act, c_en;
  int m_cnt, wr_cnt, wr_bad, rd_cnt, crc_at, c_idx;
  logic [7:0] wbytes [0:1023];
  logic [31:0] addr_log [$];
  logic [7:0] cmd_log [$];

  function automatic logic [7:0] exp_byte(int i);
    return m_seed + m_addr[7:0] + 8'(i);
  endfunction

  task automatic raise_read();
    block_read_interrupt = 1'b1;
    read_data_byte = exp_byte(m_cnt) ^ ((c_en && m_addr == 0 && m_cnt == c_idx) ? 8'hFF : 8'h00);
    if (rd_cnt == crc_at) read_crc_error = 1'b1;
  endtask

  always @(posedge clk) begin
    if (wba1) m_addr[7:0] = internal_data_bus;
    if (wba2) m_addr[15:8] = internal_data_bus;
    if (wba3) m_addr[23:16] = internal_data_bus;
    if (wba4) m_addr[31:24] = internal_data_bus;
    if (write_access_command) begin
      addr_log.push_back(m_addr);
      cmd_log.push_back(internal_data_bus);
      m_cmd = internal_data_bus;
      m_cnt = 0;
      m_act = 1'b1;
      if (m_cmd == 8'h81) request_write_data_interrupt = 1'b1;
      else raise_read();
    end else if (write_data && request_write_data_interrupt) begin
      if (wr_cnt < 1024) wbytes[wr_cnt] = internal_data_bus;
      if (internal_data_bus !== exp_byte(m_cnt)) wr_bad++;
      wr_cnt++;
      m_cnt++;
      request_write_data_interrupt = 1'b0;
    end else if (read_data && block_read_interrupt) begin
      rd_cnt++;
      m_cnt++;
      block_read_interrupt = 1'b0;
    end else if (read_data && (write_completion_interrupt || read_completion_interrupt)) begin
      write_completion_interrupt = 1'b0;
      read_completion_interrupt = 1'b0;
      m_act = 1'b0;
    end else if (m_act && !request_write_data_interrupt && !block_read_interrupt &&
                 !write_completion_interrupt && !read_completion_interrupt) begin
      if (m_cnt == 512) begin
        if (m_cmd == 8'h81) write_completion_interrupt = 1'b1;
        else read_completion_interrupt = 1'b1;
      end else if (m_cmd == 8'h81) request_write_data_interrupt = 1'b1;
      else raise_read();
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_act = 0; m_cnt = 0; wr_cnt = 0; wr_bad = 0; rd_cnt = 0; crc_at = -1; c_en = 0; c_idx = 0;
    m_addr = '0; m_cmd = '0;
    addr_log.delete();
    cmd_log.delete();
    block_read_interrupt = 0; read_completion_interrupt = 0; request_write_data_interrupt = 0;
    write_completion_interrupt = 0; read_crc_error = 0;
  endtask

  task automatic run(logic [1:0] md, logic [31:0] sb, logic [15:0] cnt, logic [7:0] sd);
    mreset();
    m_seed = sd; mode = md; start_block = sb; block_count = cnt; seed = sd;
    @(posedge clk); start = 1'b1;
    @(posedge clk); start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int k = 0;
    while (!done && k < 8000) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    mreset();
    repeat (3) @(posedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_pass", {done, pass}, 0);
    chk("rst_bus_abort", {internal_data_bus, 5'd0, abort_code}, 0);
    chk("rst_counters", {blocks_done, mismatch_count}, 0);
    reset = 1'b0;
    @(posedge clk);

    // two-block write from block 0; a start pulse mid-run must be ignored
    run(2'd0, 32'd0, 16'd2, 8'h00);
    repeat (20) @(posedge clk);
    start_block = 32'd9; start = 1'b1;
    @(posedge clk); start = 1'b0;
    wait_done("w2");
    chk("w2_strobes", wr_cnt, 1024);
    chk("w2_bad_bytes", wr_bad, 0);
    chk("w2_byte0", wbytes[0], 8'h00);
    chk("w2_byte255", wbytes[255], 8'hFF);
    chk("w2_byte512", wbytes[512], 8'h01);
    chk("w2_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD, 32'd1);
    chk("w2_blocks", blocks_done, 2);
    chk("w2_pass_abort", {pass, abort_code}, {1'b1, 3'd0});

    // write then verify block 5
    run(2'd2, 32'd5, 16'd1, 8'h10);
    wait_done("wv");
    chk("wv_cmds", addr_log.size() == 2 ? {cmd_log[0], cmd_log[1]} : 16'h0, 16'h8180);
    chk("wv_addr_w", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD, 32'd5);
    chk("wv_addr_r", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD, 32'd5);
    chk("wv_xfers", {wr_cnt[15:0], rd_cnt[15:0]}, {16'd512, 16'd512});
    chk("wv_mismatch", mismatch_count, 0);
    chk("wv_pass", {pass, blocks_done}, {1'b1, 16'd1});

    // read-compare with byte 3 of block 0 corrupted
    run(2'd1, 32'd0, 16'd1, 8'h33);
    c_en = 1'b1; c_idx = 3;
    wait_done("rc");
    chk("rc_mismatch", mismatch_count, 1);
    chk("rc_pass_abort", {pass, abort_code}, {1'b0, 3'd0});
    chk("rc_reads", rd_cnt, 512);

    // CRC error raised together with the 6th byte's interrupt
    run(2'd1, 32'd2, 16'd1, 8'h00);
    crc_at = 5;
    wait_done("crc");
    chk("crc_abort", abort_code, 3);
    chk("crc_reads", rd_cnt, 5);
    chk("crc_no_ack", {read_data, pass}, 0);

    // zero blocks: straight to DONE with pass
    run(2'd0, 32'd7, 16'd0, 8'h00);
    chk("zero_done_busy", {done, busy}, 2'b10);
    chk("zero_pass", {pass, abort_code}, {1'b1, 3'd0});
    chk("zero_blocks", blocks_done, 0);

    // drive busy forever: timeout after 16 clocks in WAIT_READY
    drive_busy = 1'b1;
    run(2'd0, 32'd0, 16'd1, 8'h00);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_abort", {done, abort_code}, {1'b1, 3'd4});
    drive_busy = 1'b0;

    // address wrap from the last block to block 0
    run(2'd0, 32'hFFFFFFFF, 16'd2, 8'h00);
    wait_done("wrap");
    chk("wrap_addr0", addr_log.size() > 0 ? addr_log[0] : 32'h0, 32'hFFFFFFFF);
    chk("wrap_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD, 32'h0);
    chk("wrap_pass", {pass, blocks_done}, {1'b1, 16'd2});

    // async reset in the middle of a byte send
    run(2'd3, 32'd4, 16'd1, 8'h00);
    n = 0;
    while (!write_data && n < 200) begin
      n++;
      @(posedge clk);
    end
    chk("rst_mid_seen_wr", 32'(write_data), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {wba1, wba2, wba3, wba4, write_access_command, write_data, read_data}, 0);
    chk("rst_mid_bus", internal_data_bus, 0);
    chk("rst_mid_flags", {busy, done, pass, abort_code}, 0);
    chk("rst_mid_counters", {blocks_done, mismatch_count}, 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
